// File: rtl/result_fmt.sv
// result_fmt: turns a 32-bit ALU result into ASCII decimal bytes for a UART.
// Define RESULT_FMT_CRLF_EN to append CR/LF after the digits.
//
// Ports:
//   clk       system clock; all state changes on its rising edge
//   n_rst     asynchronous active-low reset
//   alu_done  result-valid level from the ALU (a rising edge starts a job)
//   dtype     4'h1 = signed result, any other value = unsigned
//   calc_res  32-bit result from the ALU
//   tx_ready  UART can take a byte this cycle
//   tx_valid  tx_data holds a byte to send
//   tx_data   ASCII byte
//   fmt_busy  high in every state except IDLE
//   fmt_done  one-cycle pulse once the last byte has been taken
module result_fmt (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        alu_done,
    input  logic [3:0]  dtype,
    input  logic [31:0] calc_res,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        fmt_busy,
    output logic        fmt_done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CONV  = 3'd1;
    localparam logic [2:0] ST_SIGN  = 3'd2;
    localparam logic [2:0] ST_DIGIT = 3'd3;
    localparam logic [2:0] ST_CR    = 3'd4;
    localparam logic [2:0] ST_LF    = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        alu_done_q;
    logic        neg_q, neg_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  dig_q, dig_d;

    logic        start;
    logic        cap_neg;
    logic [39:0] bcd_adj;
    logic [39:0] bcd_shift;
    logic [31:0] bin_shift;
    logic [3:0]  lead;
    logic [3:0]  cur_dig;
    logic        unused_msb;

    // Only a 0->1 change of alu_done starts a job; a held level does not.
    assign start   = alu_done & ~alu_done_q;
    assign cap_neg = (dtype == 4'h1) & calc_res[31];

    // Double dabble step: add 3 to every digit >= 5, then shift left by one
    // bringing in the next binary bit (MSB first).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top digit never exceeds 4 for a 32-bit input, so its
    // adjusted MSB is always zero and is simply dropped.
    assign bcd_shift  = {bcd_adj[38:0], bin_q[31]};
    assign bin_shift  = {bin_q[30:0], 1'b0};
    assign unused_msb = bcd_adj[39];

    // Index of the most significant non-zero digit of the final BCD value.
    // DIGIT starts there, so leading zeros cost no cycles; 0 when all zero.
    always_comb begin
        lead = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (bcd_shift[4*i +: 4] != 4'd0) begin
                lead = 4'(i);
            end
        end
    end

    assign cur_dig = bcd_q[{dig_q, 2'b00} +: 4];

    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        dig_d    = dig_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        fmt_busy = (state_q != ST_IDLE);
        fmt_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_d   = cap_neg;
                    bin_d   = cap_neg ? (~calc_res + 32'd1) : calc_res;
                    bcd_d   = 40'd0;
                    cnt_d   = 5'd0;
                    dig_d   = 4'd0;
                    state_d = ST_CONV;
                end
            end

            ST_CONV: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    dig_d   = lead;
                    state_d = neg_q ? ST_SIGN : ST_DIGIT;
                end
            end

            ST_SIGN: begin
                tx_valid = 1'b1;
                tx_data  = 8'h2D;
                if (tx_ready) begin
                    state_d = ST_DIGIT;
                end
            end

            ST_DIGIT: begin
                tx_valid = 1'b1;
                tx_data  = {4'h3, cur_dig};
                if (tx_ready) begin
                    if (dig_q == 4'd0) begin
`ifdef RESULT_FMT_CRLF_EN
                        state_d = ST_CR;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        dig_d = dig_q - 4'd1;
                    end
                end
            end

            ST_CR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
                if (tx_ready) begin
                    state_d = ST_LF;
                end
            end

            ST_LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                fmt_done = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            alu_done_q <= 1'b0;
            neg_q      <= 1'b0;
            bin_q      <= 32'd0;
            bcd_q      <= 40'd0;
            cnt_q      <= 5'd0;
            dig_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            alu_done_q <= alu_done;
            neg_q      <= neg_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
        end
    end

endmodule

// File: tb/tb_result_fmt.sv
// tb_result_fmt: scoreboard bench for result_fmt.
// Works with RESULT_FMT_CRLF_EN defined or undefined.
module tb_result_fmt;

    logic        clk;
    logic        n_rst;
    logic        alu_done;
    logic [3:0]  dtype;
    logic [31:0] calc_res;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        fmt_busy;
    logic        fmt_done;

    result_fmt dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .alu_done (alu_done),
        .dtype    (dtype),
        .calc_res (calc_res),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .fmt_busy (fmt_busy),
        .fmt_done (fmt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int ops_issued  = 0;
    int ops_aborted = 0;
    int done_seen   = 0;
    int xfer_count  = 0;

    // 0: always ready, 1: random, 2: manual_ready
    int   ready_mode   = 0;
    logic manual_ready = 1'b1;

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = manual_ready;
            endcase
        end
    end

    // Reference model: decimal text of the value, from plain arithmetic.
    task automatic push_expect(input logic [31:0] v, input logic [3:0] dt);
        longint     sv;
        longint     mag;
        logic [7:0] d[$];
        if (dt == 4'h1) sv = longint'($signed(v));
        else            sv = longint'(v);
        mag = (sv < 0) ? -sv : sv;
        if (sv < 0) exp_q.push_back(8'h2D);
        do begin
            d.push_front(8'h30 + 8'(mag % 10));
            mag = mag / 10;
        end while (mag != 0);
        foreach (d[i]) exp_q.push_back(d[i]);
`ifdef RESULT_FMT_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Monitor: every accepted byte and every done pulse is checked.
    always @(negedge clk) begin
        if (n_rst) begin
            if (tx_valid && tx_ready) begin
                xfer_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte: unexpected byte %h, none expected",
                             tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte: got %h expected %h", tx_data, e);
                    end
                end
            end
            if (fmt_done) begin
                checks++;
                if (done_seen >= ops_issued - ops_aborted
                    || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL done: pulse with %0d bytes left, done %0d of %0d",
                             exp_q.size(), done_seen,
                             ops_issued - ops_aborted);
                end
                done_seen++;
            end
        end
    end

    task automatic start_op(input logic [31:0] v, input logic [3:0] dt);
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        @(posedge clk);
        #1;
        calc_res = v;
        dtype    = dt;
        alu_done = 1'b1;
        ops_issued++;
        push_expect(v, dt);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_seen < ops_issued - ops_aborted && n < 3000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (done_seen < ops_issued - ops_aborted) begin
            errors++;
            $display("FAIL done_timeout: done %0d required %0d",
                     done_seen, ops_issued - ops_aborted);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d bytes never sent, required 0",
                     exp_q.size());
        end
        exp_q.delete();
    endtask

    // Counts clock edges from driving alu_done high to tx_valid seen high.
    task automatic check_latency();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (fmt_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_conv: got %b required 1", fmt_busy);
                end
            end
        end while (!tx_valid && n < 100);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL latency: got %0d required 33", n);
        end
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!(tx_valid && tx_data == b) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL wait_byte: byte %h not presented", b);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 ||
            fmt_busy !== 1'b0 || fmt_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h b=%b f=%b required 0 00 0 0",
                     tag, tx_valid, tx_data, fmt_busy, fmt_done);
        end
    endtask

    logic [31:0] dir_v[9] = '{32'h0000007B, 32'hFFFFFFF6, 32'hFFFFFFF6,
                              32'h00000000, 32'h00000000, 32'h80000000,
                              32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic [3:0]  dir_t[9] = '{4'h2, 4'h1, 4'h2, 4'h2, 4'h1, 4'h1,
                              4'h2, 4'h1, 4'h1};

    initial begin
        int base;
        logic [31:0] v;
        logic [3:0]  t;
        n_rst    = 1'b0;
        alu_done = 1'b0;
        dtype    = 4'h0;
        calc_res = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        n_rst = 1'b1;

        // Directed values, with the start-to-first-byte latency checked.
        for (int i = 0; i < 9; i++) begin
            start_op(dir_v[i], dir_t[i]);
            check_latency();
            wait_done();
        end

        // Backpressure on the '2' of 123.
        ready_mode   = 2;
        manual_ready = 1'b1;
        start_op(32'd123, 4'h2);
        wait_byte(8'h31);
        manual_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h32) begin
                errors++;
                $display("FAIL stall: got v=%b d=%h required 1 32",
                         tx_valid, tx_data);
            end
        end
        manual_ready = 1'b1;
        wait_done();
        ready_mode = 0;

        // Second edge during DIGIT is ignored; held level gives no repeat.
        start_op(32'd123, 4'h2);
        wait_byte(8'h31);
        alu_done = 1'b0;
        @(negedge clk);
        alu_done = 1'b1;
        wait_done();
        base = xfer_count;
        repeat (60) @(negedge clk);
        checks++;
        if (xfer_count != base || fmt_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_repeat: got %0d bytes busy=%b required 0 0",
                     xfer_count - base, fmt_busy);
        end

        // Reset during CONV cycle 10, then a fresh job.
        start_op(32'd987654, 4'h2);
        repeat (11) @(posedge clk);
        #2;
        n_rst = 1'b0;
        ops_aborted++;
        exp_q.delete();
        alu_done = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset_conv");
        @(negedge clk);
        n_rst = 1'b1;
        base = xfer_count;
        start_op(32'd5, 4'h2);
        wait_done();
        checks++;
`ifdef RESULT_FMT_CRLF_EN
        if (xfer_count - base != 3) begin
            errors++;
            $display("FAIL post_reset: got %0d bytes required 3",
                     xfer_count - base);
        end
`else
        if (xfer_count - base != 1) begin
            errors++;
            $display("FAIL post_reset: got %0d bytes required 1",
                     xfer_count - base);
        end
`endif

        // Random values, types and backpressure.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 999);
                1:       v = 32'hFFFFFFFF - $urandom_range(0, 999);
                default: v = $urandom;
            endcase
            t = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'($urandom);
            start_op(v, t);
            wait_done();
        end
        ready_mode = 0;

        @(negedge clk);
        check_idle_outputs("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_fmt.md
RESULT_FMT -- requirements
Module: result_fmt

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port alu_done  input  1  result-valid level from alu.
REQ-004 SHALL have port dtype  input  4  4'h1 = signed, any other value = unsigned.
REQ-005 SHALL have port calc_res  input  32  two's-complement or unsigned result from alu.
REQ-006 SHALL have port tx_ready  input  1  UART transmitter can accept a byte this cycle.
REQ-007 SHALL have port tx_valid  output  1  tx_data holds a byte to send.
REQ-008 SHALL have port tx_data  output  8  ASCII byte.
REQ-009 SHALL have port fmt_busy  output  1  high from capture until fmt_done.
REQ-010 SHALL have port fmt_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-011 SHALL register alu_done each cycle and detect a rising edge: alu_done=1 with the previous sample 0.
REQ-012 SHALL capture calc_res and dtype on a rising edge seen in IDLE; edges seen in any other state SHALL be ignored and not queued.
REQ-013 SHALL use the FSM states IDLE, CONV, SIGN, DIGIT, CR, LF and DONE.
REQ-014 SHALL transition IDLE->CONV on capture.
REQ-015 SHALL exit CONV after exactly 32 cycles: to SIGN if the captured value is negative, otherwise to DIGIT.
REQ-016 SHALL treat the value as negative only when dtype==4'h1 and calc_res[31]==1; the magnitude then SHALL be the 32-bit two's-complement negation, so 0x80000000 gives 2147483648.
REQ-017 SHALL convert in CONV by shift-add-3 (double dabble), one bit per cycle, into 10 BCD digits (40 bits).
REQ-018 SHALL emit '-' (0x2D) in SIGN, then enter DIGIT.
REQ-019 SHALL emit digits in DIGIT from most to least significant as 0x30+digit.
REQ-020 SHALL suppress leading zeros in DIGIT, except that the least significant digit is always sent, so a zero value gives "0".
REQ-021 SHALL, after the last digit, go to CR when RESULT_FMT_CRLF_EN is defined, otherwise to DONE.
REQ-022 SHALL emit 0x0D in CR and 0x0A in LF, then enter DONE.
REQ-023 SHALL treat a byte as transferred only in a cycle where tx_valid and tx_ready are both high.
REQ-024 SHALL hold tx_valid and tx_data stable while tx_ready is low.
REQ-025 SHALL allow the next byte to be presented in the cycle after a transfer, without idle gaps.
REQ-026 SHALL pulse fmt_done high for one cycle in DONE, then return to IDLE.
REQ-027 SHALL drive fmt_busy=1 in every state except IDLE.
REQ-028 SHALL drive tx_valid=1 only in SIGN, DIGIT (non-suppressed digits), CR and LF.
REQ-029 SHALL first assert tx_valid 33 cycles after the capture edge.

Reset
REQ-030 SHALL, while n_rst=0, immediately force the state to IDLE.
REQ-031 SHALL, while n_rst=0, drive tx_valid=0, tx_data=8'h00, fmt_busy=0 and fmt_done=0.
REQ-032 SHALL, while n_rst=0, clear the BCD register, the captured operands, the counters and the alu_done sample.
REQ-033 SHALL abandon an operation interrupted by reset with no partial output after release, and SHALL accept the first alu_done rising edge after release.

Configuration
REQ-034 SHALL append CR (0x0D) and LF (0x0A) after the digits when RESULT_FMT_CRLF_EN is defined.
REQ-035 SHALL omit CR/LF when RESULT_FMT_CRLF_EN is undefined, so the CR and LF states are unreachable and DONE follows the last digit.

Verification (RESULT_FMT_CRLF_EN defined unless noted; tx_ready=1 unless noted)
REQ-036 SHALL cover: dtype=2, calc_res=0x0000007B -> bytes 31 32 33 0D 0A, then a fmt_done pulse.
REQ-037 SHALL cover: dtype=1, calc_res=0xFFFFFFF6 -> 2D 31 30 0D 0A; dtype=2 with the same value -> "4294967286" 0D 0A.
REQ-038 SHALL cover: calc_res=0 -> 30 0D 0A; dtype=1, calc_res=0x80000000 -> "-2147483648" 0D 0A; dtype=2, calc_res=0xFFFFFFFF -> "4294967295" 0D 0A.
REQ-039 SHALL cover: tx_ready held low for 5 cycles while the '2' of 123 is pending -> tx_data stays 0x32 with tx_valid high, and the byte order is unchanged.
REQ-040 SHALL cover: a second alu_done edge during DIGIT is ignored, and alu_done held high after DONE produces no repeat output.
REQ-041 SHALL cover: n_rst pulsed low in CONV cycle 10 -> all outputs 0; a subsequent edge with 0x00000005 -> 35 0D 0A; with RESULT_FMT_CRLF_EN undefined -> 35 only.
